// File: rtl/apb_slv_pkg.sv
// Shared definitions for apb_slave_ctrl: FSM state encoding and APB response codes.
package apb_slv_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        WAIT_RD = 2'b10,
        RESP    = 2'b11
    } state_e;

    localparam logic RESP_OKAY   = 1'b0;
    localparam logic RESP_SLVERR = 1'b1;

    // Width of the backend wait counter; covers TIMEOUT_CYC up to 65535.
    localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/apb_slv_decode.sv
// Address window decode for apb_slave_ctrl: hit flag and byte offset from BASE_ADDR.
module apb_slv_decode #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [ADDR_W-1:0] ADDR_SIZE = ADDR_W'(32'h0000_1000)
) (
    input  logic [ADDR_W-1:0] i_paddr,
    output logic              o_hit,
    output logic [ADDR_W-1:0] o_offset
);

    // Comparing the offset rather than BASE_ADDR+ADDR_SIZE stays correct when
    // the window ends exactly at the top of the address space.
    always_comb begin
        o_offset = i_paddr - BASE_ADDR;
        o_hit    = (i_paddr >= BASE_ADDR) && (o_offset < ADDR_SIZE);
    end

endmodule

// File: rtl/apb_slave_ctrl.sv
// APB slave that forwards decoded transfers to a valid/ready backend with registered outputs.
// Optional backend timeout is built when APB_SLV_TIMEOUT_EN is defined.
module apb_slave_ctrl
    import apb_slv_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h0000_0000),
    parameter logic [ADDR_W-1:0] ADDR_SIZE   = ADDR_W'(32'h0000_1000),
    parameter int unsigned       TIMEOUT_CYC = 16
) (
    input  logic                  i_clk_apb,
    input  logic                  i_rstn_apb,
    input  logic                  i_psel,
    input  logic                  i_penable,
    input  logic                  i_pwrite,
    input  logic [ADDR_W-1:0]     i_paddr,
    input  logic [DATA_W-1:0]     i_pwdata,
    input  logic [DATA_W/8-1:0]   i_pstrb,
    output logic                  o_pready,
    output logic [DATA_W-1:0]     o_prdata,
    output logic                  o_pslverr,
    output logic                  o_valid,
    output logic [ADDR_W-1:0]     o_addr,
    output logic                  o_rd0_wr1,
    output logic [DATA_W-1:0]     o_wr_data,
    output logic [DATA_W/8-1:0]   o_wr_strb,
    input  logic                  i_ready,
    input  logic                  i_rd_valid,
    input  logic [DATA_W-1:0]     i_rd_data,
    input  logic                  i_err
);

    localparam int unsigned STRB_W = DATA_W / 8;

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535 ||
        !(DATA_W == 8 || DATA_W == 16 || DATA_W == 32)) begin : g_bad_config
        $error("apb_slave_ctrl: TIMEOUT_CYC must be 1..65535 and DATA_W one of 8/16/32");
    end

    state_e              state_q,   state_d;
    logic                valid_q,   valid_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic                wr_q,      wr_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic [STRB_W-1:0]   strb_q,    strb_d;
    logic                pready_q,  pready_d;
    logic                pslverr_q, pslverr_d;
    logic [DATA_W-1:0]   prdata_q,  prdata_d;
`ifdef APB_SLV_TIMEOUT_EN
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
`endif

    logic                dec_hit;
    logic [ADDR_W-1:0]   dec_offset;

    apb_slv_decode #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_decode (
        .i_paddr  (i_paddr),
        .o_hit    (dec_hit),
        .o_offset (dec_offset)
    );

    always_comb begin
        // NOTE: every _d takes a default before the case, so no path can infer a latch.
        state_d   = state_q;
        valid_d   = valid_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        pready_d  = 1'b0;
        pslverr_d = RESP_OKAY;
        prdata_d  = '0;
`ifdef APB_SLV_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (i_psel && !i_penable) begin
                    addr_d  = dec_offset;
                    wr_d    = i_pwrite;
                    wdata_d = i_pwrite ? i_pwdata : '0;
                    strb_d  = i_pwrite ? i_pstrb  : '0;
                    if (dec_hit) begin
                        state_d = REQ;
                        valid_d = 1'b1;
`ifdef APB_SLV_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d   = RESP;
                        pready_d  = 1'b1;
                        pslverr_d = RESP_SLVERR;
                    end
                end
            end

            REQ: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    if (wr_q) begin
                        state_d   = RESP;
                        pready_d  = 1'b1;
                        pslverr_d = i_err ? RESP_SLVERR : RESP_OKAY;
                    end else if (i_rd_valid) begin
                        state_d   = RESP;
                        pready_d  = 1'b1;
                        pslverr_d = i_err ? RESP_SLVERR : RESP_OKAY;
                        prdata_d  = i_err ? '0 : i_rd_data;
                    end else begin
                        state_d = WAIT_RD;
                    end
                end
            end

            WAIT_RD: begin
                if (i_rd_valid) begin
                    state_d   = RESP;
                    pready_d  = 1'b1;
                    pslverr_d = i_err ? RESP_SLVERR : RESP_OKAY;
                    prdata_d  = i_err ? '0 : i_rd_data;
                end
            end

            RESP: begin
                // Hold the response only while the master is still between phases.
                if (i_psel && !i_penable) begin
                    pready_d  = pready_q;
                    pslverr_d = pslverr_q;
                    prdata_d  = prdata_q;
                end else begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

`ifdef APB_SLV_TIMEOUT_EN
        // A backend response arriving on the limit cycle still wins over the timeout.
        if (state_q == REQ || state_q == WAIT_RD) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (state_d != RESP && cnt_d == CNT_W'(TIMEOUT_CYC)) begin
                state_d   = RESP;
                valid_d   = 1'b0;
                pready_d  = 1'b1;
                pslverr_d = RESP_SLVERR;
                prdata_d  = '0;
            end
        end
`endif
    end

    always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
        if (!i_rstn_apb) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= RESP_OKAY;
            prdata_q  <= '0;
`ifdef APB_SLV_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
`ifdef APB_SLV_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign o_valid   = valid_q;
    assign o_addr    = addr_q;
    assign o_rd0_wr1 = wr_q;
    assign o_wr_data = wdata_q;
    assign o_wr_strb = strb_q;
    assign o_pready  = pready_q;
    assign o_pslverr = pslverr_q;
    assign o_prdata  = prdata_q;

endmodule

// File: doc/apb_slave_ctrl.md
APB_SLAVE_CTRL -- requirements
Module: apb_slave_ctrl

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  ADDR_W, 32, APB and backend address width.
  DATA_W, 32, data width (8, 16 or 32); STRB_W = DATA_W/8.
  BASE_ADDR, 32'h0000_0000, first decoded byte address.
  ADDR_SIZE, 32'h0000_1000, decoded window size in bytes.
  TIMEOUT_CYC, 16, backend wait limit in cycles (range 1..65535).
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  i_clk_apb  in  1  clock, rising edge.
  i_rstn_apb  in  1  asynchronous active-low reset.
  i_psel  in  1  APB select.
  i_penable  in  1  APB access phase.
  i_pwrite  in  1  1 = write.
  i_paddr  in  ADDR_W  APB address.
  i_pwdata  in  DATA_W  APB write data.
  i_pstrb  in  STRB_W  APB write strobes.
  o_pready  out  1  transfer complete.
  o_prdata  out  DATA_W  read data.
  o_pslverr  out  1  error response.
  o_valid  out  1  backend request valid.
  o_addr  out  ADDR_W  backend address, offset from BASE_ADDR.
  o_rd0_wr1  out  1  backend direction.
  o_wr_data  out  DATA_W  backend write data.
  o_wr_strb  out  STRB_W  backend strobes.
  i_ready  in  1  backend accepts the request.
  i_rd_valid  in  1  backend read data valid.
  i_rd_data  in  DATA_W  backend read data.
  i_err  in  1  backend error, sampled with i_ready (write) or i_rd_valid (read).
REQ-003 There SHALL be one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 The FSM SHALL have the states IDLE, REQ, WAIT_RD and RESP, and all outputs SHALL be registered.
REQ-005 In IDLE, when i_psel=1 and i_penable=0 (setup phase), the block SHALL latch paddr, pwdata, pwrite and pstrb.
REQ-006 From IDLE, a hit (BASE_ADDR <= paddr < BASE_ADDR+ADDR_SIZE) SHALL move to REQ and assert o_valid on the next cycle.
REQ-007 From IDLE, a miss SHALL move directly to RESP with the error flag set, and SHALL issue no backend request.
REQ-008 In REQ, o_valid and o_addr/o_rd0_wr1/o_wr_data/o_wr_strb SHALL be held stable until i_ready=1.
REQ-009 For reads, o_wr_data and o_wr_strb SHALL be 0.
REQ-010 In REQ with i_ready=1, a write SHALL go to RESP and capture i_err.
REQ-011 In REQ with i_ready=1, a read with i_rd_valid=1 in the same cycle SHALL capture i_rd_data and i_err and go to RESP.
REQ-012 In REQ with i_ready=1, a read without i_rd_valid SHALL go to WAIT_RD; o_valid SHALL drop the cycle after the handshake.
REQ-013 In WAIT_RD, i_rd_valid=1 SHALL capture i_rd_data and i_err and go to RESP.
REQ-014 In RESP, o_pready SHALL be 1; o_prdata SHALL be the captured data for reads, and 0 for writes and errors; o_pslverr SHALL be the captured error.
REQ-015 RESP SHALL go to IDLE once i_psel=1 and i_penable=1 are seen.
REQ-016 If i_psel=0 while in RESP, the block SHALL return to IDLE without completing the transfer.
REQ-017 o_pready, o_pslverr and o_prdata SHALL be 0 outside RESP; o_pready SHALL be high for exactly one cycle per transfer.
REQ-018 Best-case timing SHALL be: setup at T0, REQ at T1 with i_ready=1, o_pready at T2, i.e. one APB wait state.
REQ-019 i_rd_valid outside REQ/WAIT_RD SHALL be ignored.
REQ-020 A new setup phase SHALL be accepted in the cycle IDLE is re-entered.
REQ-021 i_psel dropping during REQ or WAIT_RD SHALL NOT abort the backend handshake.

Reset
REQ-022 Reset SHALL force state IDLE and all outputs and captured registers to 0, immediately, including mid-transfer.
REQ-023 After reset release, the first setup phase SHALL be accepted on the first rising edge.

Configuration
REQ-024 With APB_SLV_TIMEOUT_EN defined, a counter SHALL clear on entry to REQ and increment each cycle in REQ or WAIT_RD.
REQ-025 With APB_SLV_TIMEOUT_EN defined, reaching TIMEOUT_CYC SHALL drop o_valid, go to RESP with o_pslverr=1 and o_prdata=0, and ignore later backend responses.
REQ-026 Without APB_SLV_TIMEOUT_EN, no counter SHALL be built and REQ/WAIT_RD SHALL wait indefinitely.

Structure
REQ-027 Package apb_slv_pkg SHALL hold the state enum (IDLE=2'b00, REQ=2'b01, WAIT_RD=2'b10, RESP=2'b11) and the response constants RESP_OKAY=1'b0 and RESP_SLVERR=1'b1.
REQ-028 Address decode SHALL be implemented in the sub-module apb_slv_decode (combinational hit flag plus offset), instantiated once.

Verification
REQ-029 Write 0x...0010, data 0xA5A5_1234, strobe 4'b0011, i_ready=1 at T1 -> o_wr_strb=0011 and o_addr=0x10 at T1; o_pready=1 and o_pslverr=0 at T2.
REQ-030 Read 0x...0020 with i_ready at T1 and i_rd_valid=1, data 0xDEAD_BEEF at T4 -> o_pready=1 and o_prdata=0xDEAD_BEEF at T5, and o_pready is never high earlier.
REQ-031 Read BASE_ADDR+ADDR_SIZE (miss) -> o_pready=1 and o_pslverr=1 at T1, and o_valid is never asserted.
REQ-032 Write with i_ready=1 and i_err=1 -> o_pslverr=1 with o_pready at T2.
REQ-033 APB_SLV_TIMEOUT_EN with TIMEOUT_CYC=4 and i_ready held 0 -> o_valid drops after 4 cycles; o_pslverr=1 and o_prdata=0 the following cycle.
REQ-034 Reset asserted in WAIT_RD, then a back-to-back read after release -> all outputs 0 during reset, and the second transfer completes normally.
